// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART blocks
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 4;

  // STATUS only has four bits for the count, so deep FIFOs saturate the field
  function automatic logic [3:0] sat_count4(input int unsigned n);
    logic [31:0] v;
    v = n;
    return (v > 32'd15) ? 4'hF : v[3:0];
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// rtl/uart_tx_mmio_if.sv - processor data-bus view of the UART register window
interface uart_tx_mmio_if;

  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_in_i;
  logic [31:0] data_out_o;
  logic        sel_o;

  modport master (
    output addr_i, we_i, data_in_i,
    input  data_out_o, sel_o
  );

  modport slave (
    input  addr_i, we_i, data_in_i,
    output data_out_o, sel_o
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_q];

  // A push into a full FIFO is still legal when the head leaves on the same edge
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0010,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           reset_i,
  uart_tx_mmio_if.slave  bus,
  output logic           tx_o
);

  localparam int              TW   = $clog2(CLKS_PER_BIT);
  localparam int              CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0]   TMAX = TW'(CLKS_PER_BIT - 1);

  tx_state_t       state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic [31:0]     data_out_q, data_out_d;
  logic            sel_q;

  logic            hit, wr_txdata, wr_status, push, pop;
  logic [1:0]      offset;
  logic [7:0]      fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     status;
  logic            unused_bits;

  assign unused_bits = ^{bus.data_in_i[31:8], bus.addr_i[1:0]};

  assign hit       = (bus.addr_i[31:4] == BASE_ADDR[31:4]);
  assign offset    = bus.addr_i[3:2];
  assign wr_txdata = hit & bus.we_i & (offset == REG_TXDATA);
  assign wr_status = hit & bus.we_i & (offset == REG_STATUS);
  assign push      = wr_txdata & (~fifo_full | pop);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (bus.data_in_i[7:0]),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status                       = '0;
    status[ST_BUSY]              = (state_q != IDLE) | ~fifo_empty;
    status[ST_FULL]              = fifo_full;
    status[ST_EMPTY]             = fifo_empty;
    status[ST_OVF]               = ovf_q;
    status[ST_COUNT_LSB +: 4]    = sat_count4(32'(fifo_count));
  end

  always_comb begin
    data_out_d = '0;
    if (hit && !bus.we_i && offset == REG_STATUS) data_out_d = status;
  end

  // A dropped byte on the same edge as a clear leaves overflow set
  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && bus.data_in_i[ST_OVF]) ovf_d = 1'b0;
    if (wr_txdata && !push)                 ovf_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          timer_d = TMAX;
          state_d = START;
        end
      end
      START: begin
        if (timer_q == '0) begin
          timer_d = TMAX;
          idx_d   = 3'd0;
          state_d = DATA;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          shift_d = {1'b0, shift_q[7:1]};
          timer_d = TMAX;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            timer_d = TMAX;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level is registered off the next state so it changes on the transition edge
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
      data_out_q <= '0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
      data_out_q <= data_out_d;
      sel_q      <= hit;
    end
  end

  assign tx_o           = tx_q;
  assign bus.data_out_o = data_out_q;
  assign bus.sel_o      = sel_q;

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the processor data bus, alongside the memory block; decodes its own address window.
- Processor stores bytes into an internal FIFO, and a serial shifter drains the FIFO onto tx_o as 8N1 frames.
- Gives the processor a text console in addition to the 8-bit display.
- Its data_out_o is muxed into the processor's data_in_i by the top level when the address hits this block.

Parameters:
- BASE_ADDR, 32'hFFFF_0010, word-aligned base of the 16-byte register window.
- CLKS_PER_BIT, 868, clk cycles per serial bit; must be at least 2.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_i  input  1  asynchronous, active-high reset.
- addr_i  input  32  bus byte address from processor.
- we_i  input  1  write strobe, one cycle per store.
- data_in_i  input  32  write data from processor.
- data_out_o  output  32  read data to processor.
- sel_o  output  1  registered: high when the previous-cycle address hit the window; used by the top-level read mux.
- tx_o  output  1  serial line, idle high.

Behaviour:
- Decided interface: one clock (clk); reset_i is asynchronous, active-high. All state is cleared on assertion; deassertion is sampled by clk.
- Reset values: tx_o=1, data_out_o=0, sel_o=0, FIFO empty, overflow=0, FSM=IDLE, bit timer=0, bit index=0.
- Hit: addr_i[31:4]==BASE_ADDR[31:4]. Offset is addr_i[3:2]: 0=TXDATA, 1=STATUS, 2/3 reserved.
- Reserved offsets read as 0; writes to them are ignored.
- Write to TXDATA (hit & we_i):
  - Pushes data_in_i[7:0] into the FIFO at that edge.
  - The push is accepted if count<FIFO_DEPTH, or if a pop occurs on the same edge.
  - Otherwise the byte is dropped and overflow sets (sticky).
- Write to STATUS with data_in_i[3]=1 clears overflow.
- If a clear and a new overflow occur on the same edge, the overflow set wins.
- Read timing: data_out_o is registered, one-cycle latency. It is sampled from the current address and state, and is 0 when there is no hit or we_i=1.
- STATUS read fields:
  - [0] busy = (FSM!=IDLE) or FIFO not empty.
  - [1] full.
  - [2] empty.
  - [3] overflow.
  - [7:4] count, saturating field width log2(FIFO_DEPTH)+1, zero-extended.
  - All other bits are 0.
- TXDATA reads as 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop the head into the shift register, load the bit timer with CLKS_PER_BIT-1, go to START; tx_o=0 from this edge.
  - START: tx_o=0. When timer==0, reload the timer, set bit index=0, go to DATA.
  - DATA: tx_o=shift[0], LSB first. When timer==0: shift right, reload the timer, increment the index. After index 7 completes, go to STOP.
  - STOP: tx_o=1. When timer==0: if FIFO not empty, pop and go to START (no idle gap); else go to IDLE.
- Timing: each bit lasts exactly CLKS_PER_BIT cycles; a frame lasts 10*CLKS_PER_BIT cycles.
- Latency: a write to an empty, idle block at edge N makes tx_o fall at edge N+1.
- Timer: a down-counter of width $clog2(CLKS_PER_BIT). It only reloads, never wraps below 0.
- FIFO pointers: log2(FIFO_DEPTH) bits, natural wrap. Count ranges 0..FIFO_DEPTH.
- Reset mid-frame: tx_o returns to 1 immediately (asynchronous) and FIFO contents are discarded.

Decomposition:
- Package uart_pkg holds:
  - the state enum tx_state_t {IDLE, START, DATA, STOP};
  - register offset constants REG_TXDATA=2'd0 and REG_STATUS=2'd1;
  - STATUS bit-position constants.
- One sub-module, sync_fifo (parameterised width/depth, push/pop/full/empty/count, async active-high reset), reused later for UART RX.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset, then idle 50 cycles -> tx_o stays 1; STATUS read returns 32'h4 (empty).
- Write 0xA5 to TXDATA -> tx_o=0 one cycle later; the line carries 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles (40 cycles total); then STATUS=32'h4.
- Write 0x01 then 0x80 back-to-back -> two frames with no idle cycle between the stop bit of the first and the start bit of the second.
- Write 6 bytes in 6 consecutive cycles -> 5 accepted (1 popped immediately + 4 in FIFO), 1 dropped; STATUS shows full=1, overflow=1, count=4; 5 frames are transmitted.
- Write 32'h8 to STATUS -> overflow clears; busy is unaffected.
- Assert reset_i mid-DATA bit -> tx_o=1 in the same cycle; after release, STATUS=32'h4 and no further frame is emitted.
